tt_dfd_generic_pipe: RTL and testbench
======================================

# tt_dfd_generic_pipe

Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit data, each stage with its own valid bit. Transfers use a valid/ready handshake, and bubbles collapse, so an empty stage is filled while later stages stall. The block adds synchronous flush, a global enable and an occupancy count. It is the default retiming and buffering primitive on DFD trace and debug datapaths, replacing chains of single enabled flops.

## Interface
- WIDTH, 8, data width in bits (≥1).
- DEPTH, 2, number of register stages (0 selects combinational bypass).
- RESET_VALUE, 0, value loaded into every stage data register on reset, cast to WIDTH bits.
- CLEAR_ON_FLUSH, 0, when 1 a flush also reloads stage data with RESET_VALUE.
- CNT_W, $clog2(DEPTH+1), width of the occupancy output (minimum 1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- en  input  1  global enable; 0 freezes the pipeline.
- flush  input  1  synchronous flush of all valid stages.
- in_valid  input  1  upstream data valid.
- in_data  input  WIDTH  upstream data.
- in_ready  output  1  pipeline accepts in_data this cycle.
- out_valid  output  1  stage DEPTH-1 holds valid data.
- out_data  output  WIDTH  data of stage DEPTH-1.
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  CNT_W  number of valid stages.

## Operation
- State: per stage i (0..DEPTH-1), a valid bit v[i] and a data register d[i]. Stage 0 is the input end; stage DEPTH-1 is the output end.
- Reset (rst_n=0 at an edge): all v cleared and all d loaded with RESET_VALUE. This gives out_valid=0, out_data=RESET_VALUE and count=0 in the following cycle.
- Stage advance rule: adv[DEPTH-1] = out_valid & out_ready. For i<DEPTH-1, adv[i] = v[i] & (!v[i+1] | adv[i+1]).
- Stage i captures when its upstream holds data and it is empty or advancing:
  - Upstream for stage 0 is the input handshake; upstream for stage i>0 is v[i-1].
  - On capture, d[i] <= upstream data and v[i] <= 1.
  - If stage i advances without capturing, v[i] <= 0.
  - d[i] is written only on capture; it holds otherwise.
- in_ready = en & !flush & (!v[0] | adv[0]).
- Ready propagates combinationally from out_ready to in_ready through DEPTH stages. This path is intentional and documented.
- out_valid = en & v[DEPTH-1]. out_data = d[DEPTH-1], which is not gated.
- en=0: no capture and no advance, so all state holds. in_ready=0 and out_valid=0. Flush still takes effect.
- flush=1 at an edge:
  - All v <= 0. No capture occurs that cycle.
  - An output handshake in the flush cycle (out_valid & out_ready) still completes, and the consumer owns that word.
  - With CLEAR_ON_FLUSH=1, all d <= RESET_VALUE.
- Reset has priority over flush. Flush has priority over capture. Reset mid-transfer discards all data, and no handshake completes that cycle.
- count = popcount(v), registered-state based, ignoring en.
- DEPTH=0: out_valid=in_valid&en, out_data=in_data, in_ready=out_ready&en&!flush, count=0. No flops.
- Data is ordered strictly FIFO. There is no duplication and no loss except on flush or reset.

## Timing
- Latency into an empty, unstalled pipe: a word accepted in cycle c is presented at out_valid in cycle c+DEPTH.
- Throughput is one word per cycle with out_ready held high.
- When full and out_ready=1, in_ready=1 in the same cycle. A full pipe accepts and emits simultaneously with no bubble.
- With out_ready held low, the pipe fills to DEPTH words. in_ready drops in the cycle count reaches DEPTH with v[0]=1.
- Bubble collapse: a word behind a stalled stage advances each cycle until it is adjacent to the stall.
- count updates one cycle after the capture or advance edge.

## Test plan
- Reset with WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5 -> out_valid=0, out_data=8'hA5, count=0, in_ready=1 in the cycle after reset.
- Stream 0x01..0x10 with out_ready=1 -> out_valid first high 3 cycles after the first accept; outputs are 0x01..0x10 in order, one per cycle, with no gaps.
- Hold out_ready=0 and offer 5 words -> 3 accepted, count=3, in_ready=0. Release out_ready -> words emerge in order, and the 4th word is accepted in the first released cycle.
- Fill the pipe with 3 words, then assert flush with in_valid=1 and out_ready=1 -> the first word is consumed, nothing else is accepted, and next cycle count=0 and out_valid=0. With CLEAR_ON_FLUSH=1, out_data=RESET_VALUE.
- Drop en for 4 cycles mid-stream -> in_ready=0, out_valid=0 and count constant throughout. On resume the sequence continues with no loss or duplicate.
- DEPTH=0 build: in_data=0x3C with in_valid=1 and out_ready=1 -> out_valid=1 and out_data=0x3C in the same cycle, count=0.

Source files
------------

// File: rtl/tt_dfd_generic_pipe.sv
// Elastic valid/ready register pipeline with bubble collapse, flush, global enable
// and occupancy count. DEPTH=0 degenerates to a combinational pass-through.
module tt_dfd_generic_pipe #(
   parameter int               WIDTH          = 8,
   parameter int               DEPTH          = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
   parameter int               CLEAR_ON_FLUSH = 0,
   parameter int               CNT_W          = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out_valid      = in_valid & en;
      assign out_data       = in_data;
      assign in_ready       = out_ready & en & !flush;
      assign count          = '0;
   end else begin : g_pipe
      logic [DEPTH-1:0]            vld_pipe;
      logic [DEPTH-1:0]            adv;
      logic [DEPTH-1:0]            cap;
      logic [DEPTH-1:0][WIDTH-1:0] dat_q;
      logic [DEPTH-1:0][WIDTH-1:0] up_dat;

      assign out_valid = en & vld_pipe[DEPTH-1];
      assign out_data  = dat_q[DEPTH-1];
      assign in_ready  = en & !flush & (!vld_pipe[0] | adv[0]);

      // Ready ripples from the output end back to stage 0 in one cycle.
      always_comb begin
         adv            = '0;
         cap            = '0;
         up_dat         = '0;
         adv[DEPTH-1]   = en & vld_pipe[DEPTH-1] & out_ready;
         for (int i = DEPTH - 2; i >= 0; i--)
            adv[i] = en & vld_pipe[i] & (!vld_pipe[i+1] | adv[i+1]);
         cap[0]    = in_valid & en & !flush & (!vld_pipe[0] | adv[0]);
         up_dat[0] = in_data;
         for (int i = 1; i < DEPTH; i++) begin
            cap[i]    = adv[i-1] & !flush;
            up_dat[i] = dat_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            vld_pipe <= '0;
            dat_q    <= {DEPTH{RESET_VALUE}};
         end else if (flush) begin
            vld_pipe <= '0;
            if (CLEAR_ON_FLUSH != 0)
               dat_q <= {DEPTH{RESET_VALUE}};
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (cap[i]) begin
                  vld_pipe[i] <= 1'b1;
                  dat_q[i]    <= up_dat[i];
               end else if (adv[i]) begin
                  vld_pipe[i] <= 1'b0;
               end
            end
         end
      end

      always_comb begin
         count = '0;
         for (int i = 0; i < DEPTH; i++)
            count = count + CNT_W'(vld_pipe[i]);
      end
   end

endmodule

// File: tb/tb_tt_dfd_generic_pipe.sv
// Directed vector bench: a DEPTH=3 pipe (RESET_VALUE=A5, clear on flush) and a DEPTH=0 bypass.
module tb_tt_dfd_generic_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, flush, in_valid, out_ready;
   logic [7:0] in_data;
   logic       in_ready, out_valid;
   logic [7:0] out_data;
   logic [1:0] count;
   logic       z_in_ready, z_out_valid;
   logic [7:0] z_out_data;
   logic [0:0] z_count;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   tt_dfd_generic_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5), .CLEAR_ON_FLUSH(1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .count(count));

   tt_dfd_generic_pipe #(.WIDTH(8), .DEPTH(0), .RESET_VALUE(8'hA5), .CLEAR_ON_FLUSH(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(z_in_ready),
      .out_valid(z_out_valid), .out_data(z_out_data), .out_ready(out_ready),
      .count(z_count));

   typedef struct {
      logic       iv;
      logic [7:0] id;
      logic       ordy;
      logic       en;
      logic       fl;
      logic       x_ir;
      logic       x_ov;
      logic [7:0] x_od;
      logic [1:0] x_cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic iv, input logic [7:0] id, input logic ordy, input logic e,
                      input logic fl, input logic ir, input logic ov, input logic [7:0] od,
                      input logic [1:0] cnt);
      vec_t v;
      v.iv = iv; v.id = id; v.ordy = ordy; v.en = e; v.fl = fl;
      v.x_ir = ir; v.x_ov = ov; v.x_od = od; v.x_cnt = cnt;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic iv, input logic [7:0] id, input logic ordy,
                        input logic e, input logic fl);
      in_valid = iv; in_data = id; out_ready = ordy; en = e; flush = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // stall / fill / release
      add(1, 8'h11, 0, 1, 0,  1, 0, 8'hA5, 0);
      add(1, 8'h12, 0, 1, 0,  1, 0, 8'hA5, 1);
      add(1, 8'h13, 0, 1, 0,  1, 0, 8'hA5, 2);
      add(1, 8'h14, 0, 1, 0,  0, 1, 8'h11, 3);
      add(1, 8'h14, 1, 1, 0,  1, 1, 8'h11, 3);
      add(1, 8'h15, 1, 1, 0,  1, 1, 8'h12, 3);
      add(0, 8'h00, 1, 1, 0,  1, 1, 8'h13, 3);
      add(0, 8'h00, 1, 1, 0,  1, 1, 8'h14, 2);
      add(0, 8'h00, 1, 1, 0,  1, 1, 8'h15, 1);
      add(0, 8'h00, 1, 1, 0,  1, 0, 8'h15, 0);
      // fill then flush with a live output handshake
      add(1, 8'hA1, 0, 1, 0,  1, 0, 8'h15, 0);
      add(1, 8'hA2, 0, 1, 0,  1, 0, 8'h15, 1);
      add(1, 8'hA3, 0, 1, 0,  1, 0, 8'h15, 2);
      add(1, 8'hA4, 1, 1, 1,  0, 1, 8'hA1, 3);
      add(0, 8'h00, 1, 1, 0,  1, 0, 8'hA5, 0);
      // enable dropped for four cycles mid-stream
      add(1, 8'h21, 1, 1, 0,  1, 0, 8'hA5, 0);
      add(1, 8'h22, 1, 1, 0,  1, 0, 8'hA5, 1);
      for (int i = 0; i < 4; i++) add(1, 8'h23, 1, 0, 0,  0, 0, 8'hA5, 2);
      add(1, 8'h23, 1, 1, 0,  1, 0, 8'hA5, 2);
      add(1, 8'h24, 1, 1, 0,  1, 1, 8'h21, 3);
      add(0, 8'h00, 1, 1, 0,  1, 1, 8'h22, 3);
      add(0, 8'h00, 1, 1, 0,  1, 1, 8'h23, 2);
      add(0, 8'h00, 1, 1, 0,  1, 1, 8'h24, 1);
      add(0, 8'h00, 1, 1, 0,  1, 0, 8'h24, 0);

      // reset
      rst_n = 1'b0;
      drive(0, 8'h00, 0, 1, 0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'hA5);
      chk("rst_count",     32'(count),     32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);

      foreach (tbl[k]) begin
         drive(tbl[k].iv, tbl[k].id, tbl[k].ordy, tbl[k].en, tbl[k].fl);
         #1;
         chk($sformatf("v%0d_in_ready", k),  32'(in_ready),  32'(tbl[k].x_ir));
         chk($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].x_ov));
         chk($sformatf("v%0d_out_data", k),  32'(out_data),  32'(tbl[k].x_od));
         chk($sformatf("v%0d_count", k),     32'(count),     32'(tbl[k].x_cnt));
         tick();
      end

      // full-rate stream: word accepted at cycle c appears at c+3, no gaps
      for (int k = 0; k < 20; k++) begin
         drive(k < 16, 8'(k + 1), 1, 1, 0);
         #1;
         chk($sformatf("s%0d_in_ready", k),  32'(in_ready),  32'd1);
         chk($sformatf("s%0d_out_valid", k), 32'(out_valid), 32'(k >= 3 && k < 19));
         if (k >= 3 && k < 19)
            chk($sformatf("s%0d_out_data", k), 32'(out_data), 32'(k - 2));
         tick();
      end

      // reset while holding data discards everything
      drive(1, 8'h5A, 0, 1, 0);
      tick(); tick();
      #1;
      chk("mid_count_pre", 32'(count), 32'd2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      drive(0, 8'h00, 1, 1, 0);
      #1;
      chk("mid_rst_count",     32'(count),     32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_data",  32'(out_data),  32'hA5);

      // combinational bypass build
      drive(1, 8'h3C, 1, 1, 0);
      #1;
      chk("d0_out_valid", 32'(z_out_valid), 32'd1);
      chk("d0_out_data",  32'(z_out_data),  32'h3C);
      chk("d0_in_ready",  32'(z_in_ready),  32'd1);
      chk("d0_count",     32'(z_count),     32'd0);
      drive(1, 8'h3C, 1, 1, 1);
      #1;
      chk("d0_flush_in_ready", 32'(z_in_ready), 32'd0);
      drive(1, 8'h3C, 1, 0, 0);
      #1;
      chk("d0_en_out_valid", 32'(z_out_valid), 32'd0);
      chk("d0_en_in_ready",  32'(z_in_ready),  32'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
